// File: rtl/vm_virq_arbiter.sv
// Vectored-interrupt arbiter: shares the CPU interrupt line among NREQ local sources and
// answers the wbi acknowledge, passing it down the daisy chain when nothing local is pending.
// Optional macro VIRQ_RR_EN selects round-robin arbitration instead of fixed priority.
module vm_virq_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned VEC_W = 9
) (
  input  logic                    pin_vm_clk_p,
  input  logic                    pin_vm_init_i,
  input  logic [NREQ-1:0]         pin_req_i,
  input  logic [NREQ*VEC_W-1:0]   pin_vec_i,
  output logic [NREQ-1:0]         pin_gnt_o,
  input  logic                    pin_virq_i,
  output logic                    pin_vm_virq_o,
  input  logic                    pin_wbi_stb_i,
  output logic                    pin_wbi_ack_o,
  output logic [15:0]             pin_wbi_dat_o,
  output logic                    pin_wbi_stb_o,
  input  logic                    pin_wbi_ack_i,
  input  logic [15:0]             pin_wbi_dat_i
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    PASS = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              stb_old;
  logic              ack_q, ack_d;
  logic [15:0]       dat_q, dat_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [IDX_W-1:0]  win;
  logic [VEC_W-1:0]  vec_sel;
  logic              any_req;
  logic              stb_edge;

  assign any_req  = |pin_req_i;
  assign stb_edge = pin_wbi_stb_i & ~stb_old;

`ifdef VIRQ_RR_EN
  logic [IDX_W-1:0]  rr_q, rr_d;

  // Round-robin search starting at the pointer, wrapping past the last source.
  always_comb begin
    logic [IDX_W:0] idx;
    logic           found;
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      idx = {1'b0, rr_q} + (IDX_W+1)'(k);
      if (idx >= (IDX_W+1)'(NREQ)) idx = idx - (IDX_W+1)'(NREQ);
      if (!found && pin_req_i[idx[IDX_W-1:0]]) begin
        found = 1'b1;
        win   = idx[IDX_W-1:0];
      end
    end
  end

  assign rr_d = (win == IDX_W'(NREQ - 1)) ? '0 : win + IDX_W'(1);
`else
  // Fixed priority: lowest index wins.
  always_comb begin
    win = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (pin_req_i[i]) win = IDX_W'(i);
    end
  end
`endif

  always_comb begin
    vec_sel = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (win == IDX_W'(i)) vec_sel = pin_vec_i[i*VEC_W +: VEC_W];
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    dat_d   = dat_q;
    gnt_d   = '0;
    case (state_q)
      IDLE: begin
        if (stb_edge) begin
          if (any_req) begin
            state_d = HOLD;
            ack_d   = 1'b1;
            dat_d   = 16'(vec_sel);
            gnt_d   = NREQ'(1) << win;
          end else begin
            state_d = PASS;
          end
        end
      end
      HOLD: begin
        if (!pin_wbi_stb_i) begin
          state_d = IDLE;
          ack_d   = 1'b0;
          dat_d   = '0;
        end
      end
      PASS: begin
        if (!pin_wbi_stb_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pin_vm_clk_p or posedge pin_vm_init_i) begin
    if (pin_vm_init_i) begin
      state_q <= IDLE;
      stb_old <= 1'b0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      stb_old <= pin_wbi_stb_i;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      gnt_q   <= gnt_d;
    end
  end

`ifdef VIRQ_RR_EN
  // Pointer advances only when a local source is granted.
  always_ff @(posedge pin_vm_clk_p or posedge pin_vm_init_i) begin
    if (pin_vm_init_i) begin
      rr_q <= '0;
    end else if (state_q == IDLE && stb_edge && any_req) begin
      rr_q <= rr_d;
    end
  end
`endif

  // In PASS the chain is transparent; otherwise the local registers drive the CPU.
  assign pin_vm_virq_o = any_req | pin_virq_i;
  assign pin_gnt_o     = gnt_q;
  assign pin_wbi_stb_o = (state_q == PASS) & pin_wbi_stb_i;
  assign pin_wbi_ack_o = (state_q == PASS) ? pin_wbi_ack_i : ack_q;
  assign pin_wbi_dat_o = (state_q == PASS) ? pin_wbi_dat_i : dat_q;

endmodule

// File: tb/tb_vm_virq_arbiter.sv
// Directed self-checking bench for vm_virq_arbiter (NREQ=4, VEC_W=9).
module tb_vm_virq_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [35:0] vec;
  logic [3:0]  gnt;
  logic        virq_i, virq_o;
  logic        stb_i, ack_o, stb_o, ack_i;
  logic [15:0] dat_o, dat_i;

  int n_vec = 0;
  int n_err = 0;
  int gnt_cnt;

  always #5 clk = ~clk;

  vm_virq_arbiter #(.NREQ(4), .VEC_W(9)) dut (
    .pin_vm_clk_p  (clk),
    .pin_vm_init_i (rst),
    .pin_req_i     (req),
    .pin_vec_i     (vec),
    .pin_gnt_o     (gnt),
    .pin_virq_i    (virq_i),
    .pin_vm_virq_o (virq_o),
    .pin_wbi_stb_i (stb_i),
    .pin_wbi_ack_o (ack_o),
    .pin_wbi_dat_o (dat_o),
    .pin_wbi_stb_o (stb_o),
    .pin_wbi_ack_i (ack_i),
    .pin_wbi_dat_i (dat_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst    = 1'b1;
    req    = 4'b0000;
    vec    = {9'o064, 9'o060, 9'o374, 9'o370};
    virq_i = 1'b0;
    stb_i  = 1'b0;
    ack_i  = 1'b0;
    dat_i  = 16'h0;
    tick();
    tick();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_ack", 32'(ack_o), 32'h0);
    chk("rst_dat", 32'(dat_o), 32'h0);
    chk("rst_stbo", 32'(stb_o), 32'h0);
    chk("rst_virq", 32'(virq_o), 32'h0);
    rst = 1'b0;
    tick();

    // single request on source 0
    req = 4'b0001;
    #1 chk("virq_req", 32'(virq_o), 32'h1);
    stb_i = 1'b1;
    tick();
    chk("s0_ack", 32'(ack_o), 32'h1);
    chk("s0_dat", 32'(dat_o), 32'o370);
    chk("s0_gnt", 32'(gnt), 32'b0001);
    chk("s0_stbo", 32'(stb_o), 32'h0);
    tick();
    chk("s0_gnt_off", 32'(gnt), 32'h0);
    chk("s0_dat_hold", 32'(dat_o), 32'o370);
    stb_i = 1'b0;
    tick();
    chk("s0_ack_drop", 32'(ack_o), 32'h0);
    chk("s0_dat_drop", 32'(dat_o), 32'h0);
    req = 4'b0000;
    tick();

    // two requests, two strobes
    req = 4'b0110;
    stb_i = 1'b1;
    tick();
    chk("p1_dat", 32'(dat_o), 32'o374);
    chk("p1_gnt", 32'(gnt), 32'b0010);
    stb_i = 1'b0;
    tick();
    tick();
    stb_i = 1'b1;
    tick();
`ifdef VIRQ_RR_EN
    chk("p2_dat", 32'(dat_o), 32'o060);
    chk("p2_gnt", 32'(gnt), 32'b0100);
`else
    chk("p2_dat", 32'(dat_o), 32'o374);
    chk("p2_gnt", 32'(gnt), 32'b0010);
`endif
    stb_i = 1'b0;
    req = 4'b0000;
    tick();
    tick();

    // downstream pass-through
    virq_i = 1'b1;
    #1 chk("virq_chain", 32'(virq_o), 32'h1);
    stb_i = 1'b1;
    tick();
    chk("pass_stbo", 32'(stb_o), 32'h1);
    chk("pass_ack0", 32'(ack_o), 32'h0);
    ack_i = 1'b1;
    dat_i = 16'o100;
    #1 chk("pass_ack", 32'(ack_o), 32'h1);
    chk("pass_dat", 32'(dat_o), 32'o100);
    stb_i = 1'b0;
    #1 chk("pass_stbo_low", 32'(stb_o), 32'h0);
    tick();
    chk("pass_idle_ack", 32'(ack_o), 32'h0);
    chk("pass_idle_dat", 32'(dat_o), 32'h0);
    ack_i = 1'b0;
    dat_i = 16'h0;
    virq_i = 1'b0;
    tick();

    // nothing pending anywhere: chain sees strobe, CPU gets no ack
    stb_i = 1'b1;
    tick();
    chk("none_stbo", 32'(stb_o), 32'h1);
    chk("none_ack", 32'(ack_o), 32'h0);
    stb_i = 1'b0;
    tick();

    // request drops after winner latched
    req = 4'b1000;
    stb_i = 1'b1;
    tick();
    chk("drop_dat", 32'(dat_o), 32'o064);
    chk("drop_gnt", 32'(gnt), 32'b1000);
    req = 4'b0000;
    tick();
    chk("drop_gnt_off", 32'(gnt), 32'h0);
    chk("drop_dat_hold", 32'(dat_o), 32'o064);
    tick();
    chk("drop_ack_hold", 32'(ack_o), 32'h1);
    stb_i = 1'b0;
    tick();
    chk("drop_ack_end", 32'(ack_o), 32'h0);

    // one-cycle strobe pulse
    req = 4'b0001;
    stb_i = 1'b1;
    tick();
    chk("pulse_ack", 32'(ack_o), 32'h1);
    stb_i = 1'b0;
    tick();
    chk("pulse_exit", 32'(ack_o), 32'h0);
    req = 4'b0000;
    tick();

    // asynchronous reset while holding
    req = 4'b0100;
    stb_i = 1'b1;
    tick();
    chk("hrst_pre", 32'(dat_o), 32'o060);
    #2 rst = 1'b1;
    #1 chk("hrst_ack", 32'(ack_o), 32'h0);
    chk("hrst_dat", 32'(dat_o), 32'h0);
    chk("hrst_gnt", 32'(gnt), 32'h0);
    stb_i = 1'b0;
    tick();
    rst = 1'b0;
    req = 4'b0001;
    tick();
    stb_i = 1'b1;
    tick();
    chk("hrst_after_dat", 32'(dat_o), 32'o370);
    chk("hrst_after_gnt", 32'(gnt), 32'b0001);
    stb_i = 1'b0;
    tick();

    // strobe held high ten cycles
    req = 4'b0011;
    stb_i = 1'b1;
    gnt_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      gnt_cnt += $countones(gnt);
    end
    chk("long_gnt_cnt", 32'(gnt_cnt), 32'd1);
    chk("long_ack", 32'(ack_o), 32'h1);
`ifdef VIRQ_RR_EN
    chk("long_dat", 32'(dat_o), 32'o374);
`else
    chk("long_dat", 32'(dat_o), 32'o370);
`endif
    stb_i = 1'b0;
    tick();
    chk("long_end", 32'(ack_o), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
